// File: rtl/cpu_debug_ctrl.sv
// Run-control and display front end for the multicycle CPU.
// Produces a single-cycle CPU clock enable (run / pause / single-step),
// debounces the three board keys and muxes a debug channel onto the display.
module cpu_debug_ctrl #(
  parameter int DW        = 16,
  parameter int NCH       = 4,
  parameter int DIV_WIDTH = 23,
  parameter int DB_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_mode_n,
  input  logic                    key_step_n,
  input  logic                    key_sel_n,
  input  logic [NCH*DW-1:0]       ch_data,
  output logic                    cpu_ce,
  output logic                    running,
  output logic                    heartbeat,
  output logic [$clog2(NCH)-1:0]  disp_sel,
  output logic [DW-1:0]           disp_data,
  output logic [15:0]             step_count
);

  localparam int SW = $clog2(NCH);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(NCH - 1);

  typedef enum logic [1:0] {S_RUN, S_PAUSE, S_STEP} state_t;

  // Key bit order: 0 = mode, 1 = step, 2 = select.
  logic [2:0]    key_raw;
  logic [2:0]    sync_p0, sync_p1;
  logic [2:0]    deb, deb_d;
  logic [2:0]    press;
  logic [CW-1:0] db_cnt [3];

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] div, div_nxt;
  logic [DW-1:0]        ch [NCH];

  assign key_raw = {key_sel_n, key_step_n, key_mode_n};

  // Split the flat channel bus into one word per channel.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch[k] = ch_data[k*DW +: DW];
    end
  end

  // Key conditioning: two-flop synchronizer, stable-count debounce, falling-edge press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      deb     <= '1;
      deb_d   <= '1;
      press   <= '0;
      for (int k = 0; k < 3; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      deb_d   <= deb;
      press   <= deb_d & ~deb;
      for (int k = 0; k < 3; k++) begin
        if (sync_p1[k] == deb[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          deb[k]    <= sync_p1[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CW'(1);
        end
      end
    end
  end

  // Next-state logic; the divider only counts while running and is zero otherwise.
  always_comb begin
    state_nxt = state;
    div_nxt   = '0;
    case (state)
      S_RUN: begin
        if (press[0]) state_nxt = S_PAUSE;
        else          div_nxt   = div + DIV_WIDTH'(1);
      end
      S_PAUSE: begin
        // Mode beats step when both arrive together.
        if (press[0])      state_nxt = S_RUN;
        else if (press[1]) state_nxt = S_STEP;
      end
      S_STEP:  state_nxt = S_PAUSE;
      default: state_nxt = S_RUN;
    endcase
  end

  // Run-control state and divider registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      div   <= '0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
    end
  end

  // A run tick is decided from registered state, so a same-cycle pause cannot cancel it.
  assign cpu_ce  = (state == S_STEP) || ((state == S_RUN) && (&div));
  assign running = (state == S_RUN);

  // Heartbeat and pulse counter follow every issued clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      heartbeat  <= 1'b0;
      step_count <= '0;
    end else if (cpu_ce) begin
      heartbeat  <= ~heartbeat;
      step_count <= step_count + 16'd1;
    end
  end

  // Display channel selection, active in every run-control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_sel <= '0;
    end else if (press[2]) begin
      disp_sel <= (disp_sel == SEL_LAST) ? '0 : disp_sel + SW'(1);
    end
  end

  // Registered display word, one cycle behind both channel data and selection.
  always_ff @(posedge clk) begin
    if (rst) disp_data <= '0;
    else     disp_data <= ch[disp_sel];
  end

endmodule
